fc_sequencer: RTL and testbench
===============================

FC_SEQUENCER -- requirements
Module: fc_sequencer

Interface
REQ-001 SHALL have parameter IN_SIZE, default 1024, fc layer input vector length.
REQ-002 SHALL have parameter OUT_SIZE, default 10, fc layer output vector length.
REQ-003 SHALL have parameter IDX_W, default 10, index/address width; IN_SIZE and OUT_SIZE SHALL be <= 2**IDX_W.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: start in 1 (begin pass); train in 1 (sampled with start; 1 = forward then backward); load_req in 1 (weight-load pulse request); abort in 1 (return to IDLE).
REQ-006 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); err out 1 (sticky result-index error).
REQ-007 SHALL have ports: src_rd out 1; src_addr out IDX_W; src_data in 32 (Q16.16, valid exactly one cycle after src_rd).
REQ-008 SHALL have ports: fc_forward out 1; fc_load_weights out 1; fc_in_valid out 1; fc_data out 32; fc_in_idx out IDX_W; fc_in_rdy in 1.
REQ-009 SHALL have ports: fc_out_valid in 1; fc_result in 32; fc_out_idx in IDX_W; fc_out_rdy out 1.
REQ-010 SHALL have ports: dst_we out 1; dst_addr out IDX_W; dst_data out 32.

Function
REQ-011 SHALL implement states IDLE, LOAD, FWD, BWD, DONE.
REQ-012 In IDLE, load_req SHALL go to LOAD; else start SHALL latch train and go to FWD; load_req has priority over simultaneous start.
REQ-013 LOAD SHALL assert fc_load_weights for exactly one cycle, then return to IDLE without pulsing done.
REQ-014 fc_forward SHALL be 1 in IDLE, LOAD, FWD, DONE and 0 only in BWD.
REQ-015 Phase length: FWD feeds N_feed=IN_SIZE words, expects N_res=OUT_SIZE results; BWD feeds OUT_SIZE words, expects IN_SIZE results.
REQ-016 Feed: src_rd/src_addr issue words 0..N_feed-1 in order; one-entry holding register; src_rd SHALL only issue when holding register is empty or being drained this cycle (no overwrite, no gap when fc_in_rdy stays 1).
REQ-017 Input transfer occurs on clk edge with fc_in_valid=1 and fc_in_rdy=1; fc_data/fc_in_idx SHALL hold stable while fc_in_valid=1 and fc_in_rdy=0; fc_in_idx equals source word index.
REQ-018 With fc_in_rdy held 1, throughput SHALL be one word per cycle; first fc_in_valid SHALL rise 2 cycles after entering phase.
REQ-019 fc_out_rdy SHALL be 1 throughout FWD and BWD, 0 elsewhere; results accepted concurrently with feeding.
REQ-020 Accepted result with fc_out_idx < N_res SHALL produce dst_we=1, dst_addr=fc_out_idx, dst_data=fc_result the following cycle, and increment result count.
REQ-021 Accepted result with fc_out_idx >= N_res SHALL set err, SHALL NOT write, SHALL NOT count.
REQ-022 Phase ends when all N_feed words transferred and result count = N_res; FWD then goes to BWD if latched train=1, else DONE; BWD goes to DONE.
REQ-023 Feed and result counters SHALL reset to 0 on every phase entry (no wrap carry-over).
REQ-024 DONE SHALL pulse done for one cycle, then IDLE.
REQ-025 busy SHALL be 1 in LOAD, FWD, BWD, DONE.
REQ-026 start while busy SHALL be ignored; load_req outside IDLE SHALL be ignored.
REQ-027 abort in FWD/BWD SHALL enter IDLE next cycle, clear holding register, deassert fc_in_valid/src_rd/dst_we, no done pulse; abort has priority over phase completion in the same cycle.
REQ-028 err SHALL clear only on reset or on start accepted in IDLE.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and: busy, done, err, src_rd, fc_load_weights, fc_in_valid, fc_out_rdy, dst_we = 0; fc_forward = 1; all addresses, indices, data = 0.
REQ-030 Reset mid-phase SHALL discard all progress; next start restarts at index 0.

Verification
REQ-031 IN_SIZE=4, OUT_SIZE=2, train=0, fc_in_rdy=1, src_data=addr<<16: fc_in_idx 0,1,2,3 on consecutive cycles with fc_data 0x00000000..0x00030000; results idx 0,1 -> dst writes addr 0,1; one done pulse.
REQ-032 Same sizes, train=1: FWD then fc_forward=0; feeds idx 0,1; four results idx 0..3 written; done only after 4th result.
REQ-033 fc_in_rdy toggling 1,0,0,1 during feed: fc_data/fc_in_idx held during stalls, no word lost/duplicated, all 4 idx delivered in order.
REQ-034 Result with fc_out_idx=5 in FWD (N_res=2): err=1, no dst_we; phase still needs 2 valid results; next start clears err.
REQ-035 abort after 2 feed words: IDLE next cycle, done stays 0; rst_n pulse mid-BWD: all outputs at reset values, fc_forward=1.
REQ-036 load_req and start same cycle in IDLE: one-cycle fc_load_weights, return IDLE, start ignored, busy 1 for that cycle only.

Source files
------------

// File: rtl/fc_sequencer_if.sv
// Sequencer-side buses: source memory read port, fully-connected layer
// streaming ports, and destination memory write port.
interface fc_sequencer_if #(
    parameter int IDX_W = 10
);
    logic             src_rd;
    logic [IDX_W-1:0] src_addr;
    logic [31:0]      src_data;

    logic             fc_forward;
    logic             fc_load_weights;
    logic             fc_in_valid;
    logic [31:0]      fc_data;
    logic [IDX_W-1:0] fc_in_idx;
    logic             fc_in_rdy;

    logic             fc_out_valid;
    logic [31:0]      fc_result;
    logic [IDX_W-1:0] fc_out_idx;
    logic             fc_out_rdy;

    logic             dst_we;
    logic [IDX_W-1:0] dst_addr;
    logic [31:0]      dst_data;

    modport master (
        output src_rd, src_addr,
        input  src_data,
        output fc_forward, fc_load_weights, fc_in_valid, fc_data, fc_in_idx,
        input  fc_in_rdy,
        input  fc_out_valid, fc_result, fc_out_idx,
        output fc_out_rdy,
        output dst_we, dst_addr, dst_data
    );

    modport slave (
        input  src_rd, src_addr,
        output src_data,
        input  fc_forward, fc_load_weights, fc_in_valid, fc_data, fc_in_idx,
        output fc_in_rdy,
        output fc_out_valid, fc_result, fc_out_idx,
        input  fc_out_rdy,
        input  dst_we, dst_addr, dst_data
    );
endinterface

// File: rtl/fc_sequencer.sv
// Drives one fully-connected layer pass: streams source words into the layer
// (forward, optionally followed by backward) and writes results to destination.
module fc_sequencer #(
    parameter int IN_SIZE  = 1024,
    parameter int OUT_SIZE = 10,
    parameter int IDX_W    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          train,
    input  logic          load_req,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    fc_sequencer_if.master bus
);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] C_IN  = CNT_W'(IN_SIZE);
    localparam logic [CNT_W-1:0] C_OUT = CNT_W'(OUT_SIZE);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FWD, S_BWD, S_DONE} state_t;

    state_t           r_state, w_state_next;
    logic             r_train, r_err;
    logic [CNT_W-1:0] r_rd_ptr, r_xfer_cnt, r_res_cnt;
    logic             r_pend;
    logic [IDX_W-1:0] r_pend_idx;
    logic             r_hold_vld;
    logic [31:0]      r_hold_data;
    logic [IDX_W-1:0] r_hold_idx;
    logic             r_dst_we;
    logic [IDX_W-1:0] r_dst_addr;
    logic [31:0]      r_dst_data;

    logic             w_phase, w_drain, w_hold_free, w_src_rd, w_drop;
    logic             w_res_acc, w_res_ok, w_phase_end, w_enter;
    logic [CNT_W-1:0] w_n_feed, w_n_res;

    assign w_phase     = (r_state == S_FWD) || (r_state == S_BWD);
    assign w_n_feed    = (r_state == S_BWD) ? C_OUT : C_IN;
    assign w_n_res     = (r_state == S_BWD) ? C_IN : C_OUT;
    assign w_drain     = r_hold_vld & bus.fc_in_rdy;
    assign w_hold_free = ~r_hold_vld | w_drain;
    assign w_src_rd    = w_phase & ~abort & (r_rd_ptr < w_n_feed) & w_hold_free;
    // A word returning while the holding register is stalled is dropped and re-read.
    assign w_drop      = r_pend & ~w_hold_free;
    assign w_res_acc   = w_phase & ~abort & bus.fc_out_valid;
    assign w_res_ok    = w_res_acc & ({1'b0, bus.fc_out_idx} < w_n_res);
    assign w_phase_end = (r_xfer_cnt == w_n_feed) && (r_res_cnt == w_n_res);
    assign w_enter     = ((w_state_next == S_FWD) && (r_state != S_FWD)) ||
                         ((w_state_next == S_BWD) && (r_state != S_BWD));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (load_req)   w_state_next = S_LOAD;
                else if (start) w_state_next = S_FWD;
            end
            S_LOAD: w_state_next = S_IDLE;
            S_FWD: begin
                if (abort)            w_state_next = S_IDLE;
                else if (w_phase_end) w_state_next = r_train ? S_BWD : S_DONE;
            end
            S_BWD: begin
                if (abort)            w_state_next = S_IDLE;
                else if (w_phase_end) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_train     <= 1'b0;
            r_err       <= 1'b0;
            r_rd_ptr    <= '0;
            r_xfer_cnt  <= '0;
            r_res_cnt   <= '0;
            r_pend      <= 1'b0;
            r_pend_idx  <= '0;
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
            r_hold_idx  <= '0;
            r_dst_we    <= 1'b0;
            r_dst_addr  <= '0;
            r_dst_data  <= '0;
        end else begin
            if ((r_state == S_IDLE) && !load_req && start) begin
                r_train <= train;
                r_err   <= 1'b0;
            end else if (w_res_acc && !w_res_ok) begin
                r_err <= 1'b1;
            end

            r_dst_we <= w_res_ok;
            if (w_res_ok) begin
                r_dst_addr <= bus.fc_out_idx;
                r_dst_data <= bus.fc_result;
            end

            if (w_enter || (w_phase && abort)) begin
                r_rd_ptr   <= '0;
                r_xfer_cnt <= '0;
                r_res_cnt  <= '0;
                r_pend     <= 1'b0;
                r_hold_vld <= 1'b0;
            end else if (w_phase) begin
                r_pend     <= w_src_rd;
                r_pend_idx <= r_rd_ptr[IDX_W-1:0];
                if (w_drop)        r_rd_ptr <= {1'b0, r_pend_idx};
                else if (w_src_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
                if (r_pend && w_hold_free) begin
                    r_hold_vld  <= 1'b1;
                    r_hold_data <= bus.src_data;
                    r_hold_idx  <= r_pend_idx;
                end else if (w_drain) begin
                    r_hold_vld <= 1'b0;
                end
                if (w_drain)  r_xfer_cnt <= r_xfer_cnt + 1'b1;
                if (w_res_ok) r_res_cnt  <= r_res_cnt + 1'b1;
            end
        end
    end

    assign busy                = (r_state != S_IDLE);
    assign done                = (r_state == S_DONE);
    assign err                 = r_err;
    assign bus.src_rd          = w_src_rd;
    assign bus.src_addr        = w_src_rd ? r_rd_ptr[IDX_W-1:0] : '0;
    assign bus.fc_forward      = (r_state != S_BWD);
    assign bus.fc_load_weights = (r_state == S_LOAD);
    assign bus.fc_in_valid     = r_hold_vld;
    assign bus.fc_data         = r_hold_data;
    assign bus.fc_in_idx       = r_hold_idx;
    assign bus.fc_out_rdy      = w_phase;
    assign bus.dst_we          = r_dst_we;
    assign bus.dst_addr        = r_dst_addr;
    assign bus.dst_data        = r_dst_data;
endmodule

// File: tb/tb_fc_sequencer.sv
// Randomized self-checking bench for fc_sequencer with a small-size layer
// (4 inputs, 2 outputs) and a pass-level reference model.
module tb_fc_sequencer;
    localparam int IN_SIZE  = 4;
    localparam int OUT_SIZE = 2;
    localparam int IDX_W    = 4;

    logic clk = 1'b0;
    logic rst_n, start, train, load_req, abort;
    logic busy, done, err;

    fc_sequencer_if #(.IDX_W(IDX_W)) bus ();

    fc_sequencer #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .train    (train),
        .load_req (load_req),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem [16];

    // Source memory: data appears one cycle after the read; junk otherwise.
    always @(posedge clk) begin
        if (bus.src_rd) bus.src_data <= mem[bus.src_addr];
        else            bus.src_data <= $urandom;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_src_rd", bus.src_rd, 0);
        chk("rst_src_addr", bus.src_addr, 0);
        chk("rst_load_w", bus.fc_load_weights, 0);
        chk("rst_fc_forward", bus.fc_forward, 1);
        chk("rst_in_valid", bus.fc_in_valid, 0);
        chk("rst_fc_data", bus.fc_data, 0);
        chk("rst_in_idx", bus.fc_in_idx, 0);
        chk("rst_out_rdy", bus.fc_out_rdy, 0);
        chk("rst_dst_we", bus.dst_we, 0);
        chk("rst_dst_addr", bus.dst_addr, 0);
        chk("rst_dst_data", bus.dst_data, 0);
    endtask

    task automatic fill_results(input int n, output int q[$]);
        int tmp;
        int j;
        q = {};
        for (int i = 0; i < n; i++) q.push_back(i);
        for (int i = n - 1; i > 0; i--) begin
            j = $urandom_range(i);
            tmp = q[i]; q[i] = q[j]; q[j] = tmp;
        end
    endtask

    // One complete pass; called and returns just after a falling edge.
    task automatic run_pass(input bit tr, input int rdy_pct, input bit inject_bad);
        int               fed, cyc, n_feed, n_res, done_seen;
        int               res_q[$];
        bit               bwd, first_seen, prev_stall, bad_done, wr_pend, exp_err, set_err;
        logic [IDX_W-1:0] prev_idx, wr_addr;
        logic [31:0]      prev_data, wr_data;

        start = 1'b1;
        train = tr;
        @(negedge clk);
        start = 1'b0;
        train = 1'($urandom);
        fed = 0; cyc = 0; done_seen = 0;
        n_feed = IN_SIZE; n_res = OUT_SIZE;
        bwd = 0; first_seen = 0; prev_stall = 0; bad_done = 0; wr_pend = 0; exp_err = 0;
        prev_idx = '0; prev_data = '0; wr_addr = '0; wr_data = '0;
        fill_results(n_res, res_q);

        for (int t = 0; t < 300; t++) begin
            if (!bwd && !bus.fc_forward) begin
                chk("fwd_complete_at_bwd", {tr, fed == n_feed, res_q.size() == 0}, 3'b111);
                bwd = 1; fed = 0; cyc = 0; first_seen = 0; prev_stall = 0;
                n_feed = OUT_SIZE; n_res = IN_SIZE;
                fill_results(n_res, res_q);
            end
            chk("busy", busy, 1);
            chk("err", err, exp_err);
            chk("dst_we", bus.dst_we, wr_pend);
            if (wr_pend) begin
                chk("dst_addr", bus.dst_addr, wr_addr);
                chk("dst_data", bus.dst_data, wr_data);
            end
            if (prev_stall) begin
                chk("stall_valid", bus.fc_in_valid, 1);
                chk("stall_idx", bus.fc_in_idx, prev_idx);
                chk("stall_data", bus.fc_data, prev_data);
            end
            if (bus.fc_in_valid && !first_seen) begin
                chk("first_valid_latency", cyc, 2);
                first_seen = 1;
            end
            if (done) begin
                chk("done_when_complete",
                    {bwd == tr, fed == n_feed, res_q.size() == 0, done_seen == 0}, 4'b1111);
                chk("done_out_rdy", bus.fc_out_rdy, 0);
                done_seen++;
                bus.fc_out_valid = 1'b0;
                bus.fc_in_rdy    = 1'b0;
                @(negedge clk);
                chk("done_one_cycle", done, 0);
                chk("idle_busy", busy, 0);
                chk("idle_err", err, exp_err);
                break;
            end
            chk("phase_out_rdy", bus.fc_out_rdy, 1);

            bus.fc_in_rdy = ($urandom_range(99) < rdy_pct);
            prev_stall = bus.fc_in_valid && !bus.fc_in_rdy;
            prev_idx   = bus.fc_in_idx;
            prev_data  = bus.fc_data;
            if (bus.fc_in_valid && bus.fc_in_rdy) begin
                chk("feed_idx", bus.fc_in_idx, fed);
                chk("feed_data", bus.fc_data, mem[fed]);
                if (rdy_pct == 100) chk("feed_rate", cyc, 2 + fed);
                fed++;
            end

            wr_pend = 0; set_err = 0;
            bus.fc_out_valid = 1'b0;
            if (bus.fc_out_rdy && res_q.size() > 0 && $urandom_range(2) == 0) begin
                bus.fc_out_valid = 1'b1;
                bus.fc_result    = $urandom;
                if (inject_bad && !bad_done && !bwd) begin
                    bus.fc_out_idx = IDX_W'(5);
                    bad_done = 1;
                    set_err  = 1;
                end else begin
                    bus.fc_out_idx = IDX_W'(res_q.pop_front());
                    wr_pend = 1;
                    wr_addr = bus.fc_out_idx;
                    wr_data = bus.fc_result;
                end
            end
            @(negedge clk);
            cyc++;
            if (set_err) exp_err = 1;
        end
        chk("pass_done_seen", done_seen, 1);
        bus.fc_out_valid = 1'b0;
    endtask

    task automatic run_abort();
        int fed;
        fed = 0;
        start = 1'b1; train = 1'b0; bus.fc_in_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (fed == 2) begin
                abort = 1'b1;
                break;
            end
            if (bus.fc_in_valid && bus.fc_in_rdy) fed++;
            @(negedge clk);
        end
        chk("abort_fed", fed, 2);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_in_valid", bus.fc_in_valid, 0);
        chk("abort_src_rd", bus.src_rd, 0);
        chk("abort_dst_we", bus.dst_we, 0);
        chk("abort_out_rdy", bus.fc_out_rdy, 0);
        for (int t = 0; t < 3; t++) begin
            chk("abort_no_done", done, 0);
            @(negedge clk);
        end
    endtask

    task automatic run_reset_mid_bwd();
        int k;
        bit saw;
        k = 0; saw = 0;
        start = 1'b1; train = 1'b1; bus.fc_in_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (!bus.fc_forward) begin
                saw = 1;
                break;
            end
            bus.fc_out_valid = (k < OUT_SIZE);
            bus.fc_out_idx   = IDX_W'(k);
            k++;
            @(negedge clk);
        end
        bus.fc_out_valid = 1'b0;
        chk("reset_reached_bwd", saw, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; train = 1'b0; load_req = 1'b0; abort = 1'b0;
        bus.fc_in_rdy = 1'b0; bus.fc_out_valid = 1'b0;
        bus.fc_result = '0; bus.fc_out_idx = '0;
        for (int i = 0; i < 16; i++) mem[i] = i << 16;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        load_req = 1'b1; start = 1'b1; train = 1'b1;
        @(negedge clk);
        load_req = 1'b0; start = 1'b0;
        chk("load_pulse", bus.fc_load_weights, 1);
        chk("load_busy", busy, 1);
        chk("load_no_done", done, 0);
        chk("load_fwd", bus.fc_forward, 1);
        @(negedge clk);
        chk("load_pulse_end", bus.fc_load_weights, 0);
        chk("load_idle", busy, 0);
        chk("load_no_done2", done, 0);
        @(negedge clk);
        chk("load_start_ignored", busy, 0);

        run_pass(1'b0, 100, 1'b0);
        run_pass(1'b1, 100, 1'b0);
        run_pass(1'b0, 50, 1'b0);
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        run_pass(1'b1, 60, 1'b0);
        run_pass(1'b0, 70, 1'b1);
        run_pass(1'b1, 70, 1'b0);
        run_abort();
        run_pass(1'b0, 60, 1'b0);
        run_reset_mid_bwd();
        run_pass(1'b1, 80, 1'b1);
        for (int p = 0; p < 6; p++)
            run_pass(1'($urandom), 30 + $urandom_range(70), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end
endmodule
